regs_port_arbiter: RTL and testbench

Sequencer and two-way arbiter for the `regs` register file. Accepts register-file transactions (read rs1/rs2, optional rd write) from two requesters, core pipeline (m0) and debug unit (m1). Grants them round-robin and converts each into the file's req/ack strobe protocol with active-low read/write enables. Returns read data through a shared response channel, and enforces x0 semantics that the file itself does not.

---
 rtl/regs_port_arbiter_if.sv | 35 +++
 rtl/regs_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_regs_port_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regs_port_arbiter_if.sv
// Bundle between the two requesters, the response consumer and the register file.
// master: requester/consumer/file side; slave: the arbiter.
interface regs_port_arbiter_if;
  logic        m0_valid, m0_ready, m0_rs_en, m0_rd_en;
  logic [4:0]  m0_rs1, m0_rs2, m0_rd;
  logic [31:0] m0_wdata;
  logic        m1_valid, m1_ready, m1_rs_en, m1_rd_en;
  logic [4:0]  m1_rs1, m1_rs2, m1_rd;
  logic [31:0] m1_wdata;
  logic        resp_valid, resp_ready, resp_id;
  logic [31:0] resp_rs1, resp_rs2;
  logic        rf_req, rf_ack, rf_rs_read_n, rf_rd_write_n;
  logic [4:0]  rf_rs1, rf_rs2, rf_rd;
  logic [31:0] rf_rd_value, rf_rs1_value, rf_rs2_value;

  modport master (
    output m0_valid, m0_rs_en, m0_rd_en, m0_rs1, m0_rs2, m0_rd, m0_wdata,
    output m1_valid, m1_rs_en, m1_rd_en, m1_rs1, m1_rs2, m1_rd, m1_wdata,
    input  m0_ready, m1_ready,
    output resp_ready,
    input  resp_valid, resp_id, resp_rs1, resp_rs2,
    input  rf_req, rf_ack, rf_rs_read_n, rf_rd_write_n, rf_rs1, rf_rs2, rf_rd, rf_rd_value,
    output rf_rs1_value, rf_rs2_value
  );

  modport slave (
    input  m0_valid, m0_rs_en, m0_rd_en, m0_rs1, m0_rs2, m0_rd, m0_wdata,
    input  m1_valid, m1_rs_en, m1_rd_en, m1_rs1, m1_rs2, m1_rd, m1_wdata,
    output m0_ready, m1_ready,
    input  resp_ready,
    output resp_valid, resp_id, resp_rs1, resp_rs2,
    output rf_req, rf_ack, rf_rs_read_n, rf_rd_write_n, rf_rs1, rf_rs2, rf_rd, rf_rd_value,
    input  rf_rs1_value, rf_rs2_value
  );
endinterface

// File: rtl/regs_port_arbiter.sv
// Round-robin two-requester sequencer for the regs file: IDLE->SETUP->STROBE->CAPTURE->RESP,
// with x0 write suppression and read-as-zero applied here rather than in the file.
module regs_port_arbiter #(
  parameter bit ZERO_X0 = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  regs_port_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, CAPTURE, RESP} state_e;

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic        id_q, id_d;
  logic        rs_en_q, rs_en_d;
  logic [4:0]  rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [31:0] wdata_q, wdata_d;
  logic        req_q, req_d;
  logic        rs_read_n_q, rs_read_n_d;
  logic        rd_write_n_q, rd_write_n_d;
  logic        resp_id_q, resp_id_d;
  logic [31:0] resp_rs1_q, resp_rs1_d, resp_rs2_q, resp_rs2_d;

  logic        grant_valid, grant_id;
  logic        sel_rs_en, sel_rd_en, sel_wr;
  logic [4:0]  sel_rs1, sel_rs2, sel_rd;
  logic [31:0] sel_wdata;

  // last_q == 1 means m1 was granted last, so m0 wins the next tie
  assign grant_valid = bus.m0_valid || bus.m1_valid;
  assign grant_id    = (bus.m0_valid && bus.m1_valid) ? ~last_q : ~bus.m0_valid;

  assign bus.m0_ready = rst_n && (state_q == IDLE) && bus.m0_valid && !grant_id;
  assign bus.m1_ready = rst_n && (state_q == IDLE) && bus.m1_valid &&  grant_id;

  assign sel_rs_en = grant_id ? bus.m1_rs_en : bus.m0_rs_en;
  assign sel_rd_en = grant_id ? bus.m1_rd_en : bus.m0_rd_en;
  assign sel_rs1   = grant_id ? bus.m1_rs1   : bus.m0_rs1;
  assign sel_rs2   = grant_id ? bus.m1_rs2   : bus.m0_rs2;
  assign sel_rd    = grant_id ? bus.m1_rd    : bus.m0_rd;
  assign sel_wdata = grant_id ? bus.m1_wdata : bus.m0_wdata;
  assign sel_wr    = sel_rd_en && !(ZERO_X0 && (sel_rd == 5'd0));

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    id_d         = id_q;
    rs_en_d      = rs_en_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    rd_d         = rd_q;
    wdata_d      = wdata_q;
    req_d        = req_q;
    rs_read_n_d  = rs_read_n_q;
    rd_write_n_d = rd_write_n_q;
    resp_id_d    = resp_id_q;
    resp_rs1_d   = resp_rs1_q;
    resp_rs2_d   = resp_rs2_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d      = SETUP;
          last_d       = grant_id;
          id_d         = grant_id;
          rs_en_d      = sel_rs_en;
          rs1_d        = sel_rs1;
          rs2_d        = sel_rs2;
          rd_d         = sel_rd;
          wdata_d      = sel_wdata;
          rs_read_n_d  = !sel_rs_en;
          rd_write_n_d = !sel_wr;
        end
      end
      SETUP: begin
        state_d = STROBE;
        req_d   = 1'b1;
      end
      STROBE: begin
        state_d      = CAPTURE;
        req_d        = 1'b0;
        rs_read_n_d  = 1'b1;
        rd_write_n_d = 1'b1;
      end
      CAPTURE: begin
        // File data was registered on the strobe edge and is valid now
        state_d    = RESP;
        resp_id_d  = id_q;
        resp_rs1_d = (rs_en_q && !(ZERO_X0 && (rs1_q == 5'd0))) ? bus.rf_rs1_value : 32'd0;
        resp_rs2_d = (rs_en_q && !(ZERO_X0 && (rs2_q == 5'd0))) ? bus.rf_rs2_value : 32'd0;
      end
      RESP: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_q       <= 1'b1;
      id_q         <= 1'b0;
      rs_en_q      <= 1'b0;
      rs1_q        <= 5'd0;
      rs2_q        <= 5'd0;
      rd_q         <= 5'd0;
      wdata_q      <= 32'd0;
      req_q        <= 1'b0;
      rs_read_n_q  <= 1'b1;
      rd_write_n_q <= 1'b1;
      resp_id_q    <= 1'b0;
      resp_rs1_q   <= 32'd0;
      resp_rs2_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      id_q         <= id_d;
      rs_en_q      <= rs_en_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
      wdata_q      <= wdata_d;
      req_q        <= req_d;
      rs_read_n_q  <= rs_read_n_d;
      rd_write_n_q <= rd_write_n_d;
      resp_id_q    <= resp_id_d;
      resp_rs1_q   <= resp_rs1_d;
      resp_rs2_q   <= resp_rs2_d;
    end
  end

  assign bus.rf_req        = req_q;
  assign bus.rf_ack        = 1'b1;
  assign bus.rf_rs_read_n  = rs_read_n_q;
  assign bus.rf_rd_write_n = rd_write_n_q;
  assign bus.rf_rs1        = rs1_q;
  assign bus.rf_rs2        = rs2_q;
  assign bus.rf_rd         = rd_q;
  assign bus.rf_rd_value   = wdata_q;
  assign bus.resp_valid    = (state_q == RESP);
  assign bus.resp_id       = resp_id_q;
  assign bus.resp_rs1      = resp_rs1_q;
  assign bus.resp_rs2      = resp_rs2_q;
endmodule

// File: tb/tb_regs_port_arbiter.sv
// Bench for regs_port_arbiter: register-file stand-in, transaction-level timing model
// checked every cycle, and directed scenarios with literal expectations.
module tb_regs_port_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regs_port_arbiter_if bus ();
  regs_port_arbiter #(.ZERO_X0(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int wr_low_cnt = 0;
  int req_cnt = 0;
  bit rst_edge = 1'b0;
  bit          grants[$];
  bit          r_id[$];
  logic [31:0] r_rs1[$];
  logic [31:0] r_rs2[$];
  logic [31:0] fmem [32];

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s cyc=%0d actual=timeout required=event", name, cyc);
  endtask

  // Register-file stand-in: samples on the clock edge where req is high; reads see pre-write data.
  initial begin : regfile
    for (int i = 0; i < 32; i++) fmem[i] = {4{8'(i)}};
    fmem[0] = 32'hBAD0_BAD0;
    bus.rf_rs1_value <= 32'hA5A5_A5A5;
    bus.rf_rs2_value <= 32'h5A5A_5A5A;
    forever begin
      @(posedge clk);
      if (bus.rf_req === 1'b1) begin
        if (!bus.rf_rs_read_n) begin
          bus.rf_rs1_value <= fmem[bus.rf_rs1];
          bus.rf_rs2_value <= fmem[bus.rf_rs2];
        end
        if (!bus.rf_rd_write_n) fmem[bus.rf_rd] = bus.rf_rd_value;
      end
    end
  end

  // Transaction model: a transfer at cycle t0 owns the file for t0+1..t0+3 and answers from t0+4.
  initial begin : compare
    logic [31:0] model_rf [32];
    bit busy, last, w, wv, e_id, e_rs_en, e_rd_en, e_wr;
    logic [4:0]  e_rs1, e_rs2, e_rd;
    logic [31:0] e_wd, e_r1, e_r2;
    int t0, k;
    for (int i = 0; i < 32; i++) model_rf[i] = {4{8'(i)}};
    model_rf[0] = 32'd0;
    busy = 1'b0; last = 1'b1; t0 = 0;
    forever begin
      @(posedge clk);
      rst_edge = !rst_n;
      cyc++;
      @(negedge clk);
      chk1("rf_ack", bus.rf_ack, 1'b1);
      if (bus.rf_rd_write_n === 1'b0) wr_low_cnt++;
      if (bus.rf_req === 1'b1) req_cnt++;
      if (rst_edge) begin
        chk1("rst_rf_req", bus.rf_req, 1'b0);
        chk1("rst_rs_read_n", bus.rf_rs_read_n, 1'b1);
        chk1("rst_rd_write_n", bus.rf_rd_write_n, 1'b1);
        chk32("rst_rf_idx", {17'd0, bus.rf_rs1, bus.rf_rs2, bus.rf_rd}, 32'd0);
        chk32("rst_rf_rd_value", bus.rf_rd_value, 32'd0);
        chk1("rst_resp_valid", bus.resp_valid, 1'b0);
        chk1("rst_resp_id", bus.resp_id, 1'b0);
        chk32("rst_resp_rs1", bus.resp_rs1, 32'd0);
        chk32("rst_resp_rs2", bus.resp_rs2, 32'd0);
        busy = 1'b0;
        last = 1'b1;
      end
      if (!rst_n) begin
        chk1("m0_ready_in_reset", bus.m0_ready, 1'b0);
        chk1("m1_ready_in_reset", bus.m1_ready, 1'b0);
      end else if (!busy) begin
        wv = bus.m0_valid || bus.m1_valid;
        w  = (bus.m0_valid && bus.m1_valid) ? !last : !bus.m0_valid;
        chk1("m0_ready", bus.m0_ready, wv && !w);
        chk1("m1_ready", bus.m1_ready, wv && w);
        chk1("idle_rf_req", bus.rf_req, 1'b0);
        chk1("idle_resp_valid", bus.resp_valid, 1'b0);
        if (wv) begin
          if (!w) begin
            e_rs_en = bus.m0_rs_en; e_rd_en = bus.m0_rd_en; e_rs1 = bus.m0_rs1;
            e_rs2 = bus.m0_rs2; e_rd = bus.m0_rd; e_wd = bus.m0_wdata;
          end else begin
            e_rs_en = bus.m1_rs_en; e_rd_en = bus.m1_rd_en; e_rs1 = bus.m1_rs1;
            e_rs2 = bus.m1_rs2; e_rd = bus.m1_rd; e_wd = bus.m1_wdata;
          end
          e_id = w;
          e_wr = e_rd_en && (e_rd != 5'd0);
          e_r1 = e_rs_en ? model_rf[e_rs1] : 32'd0;
          e_r2 = e_rs_en ? model_rf[e_rs2] : 32'd0;
          if (e_wr) model_rf[e_rd] = e_wd;
          busy = 1'b1; t0 = cyc; last = w;
          grants.push_back(w);
        end
      end else begin
        k = cyc - t0;
        chk1("busy_m0_ready", bus.m0_ready, 1'b0);
        chk1("busy_m1_ready", bus.m1_ready, 1'b0);
        chk1("rf_req", bus.rf_req, k == 2);
        chk1("rf_rs_read_n", bus.rf_rs_read_n, (k <= 2) ? !e_rs_en : 1'b1);
        chk1("rf_rd_write_n", bus.rf_rd_write_n, (k <= 2) ? !e_wr : 1'b1);
        chk32("rf_idx", {17'd0, bus.rf_rs1, bus.rf_rs2, bus.rf_rd}, {17'd0, e_rs1, e_rs2, e_rd});
        chk32("rf_rd_value", bus.rf_rd_value, e_wd);
        chk1("resp_valid", bus.resp_valid, k >= 4);
        if (k >= 4) begin
          chk1("resp_id", bus.resp_id, e_id);
          chk32("resp_rs1", bus.resp_rs1, e_r1);
          chk32("resp_rs2", bus.resp_rs2, e_r2);
          if (bus.resp_ready) begin
            busy = 1'b0;
            r_id.push_back(bus.resp_id);
            r_rs1.push_back(bus.resp_rs1);
            r_rs2.push_back(bus.resp_rs2);
            $display("txn cyc=%0d id=%0d rs1=%h rs2=%h", cyc, bus.resp_id, bus.resp_rs1, bus.resp_rs2);
          end
        end
      end
    end
  end

  task automatic set_req(input bit m, input bit v, input bit rs_en, input bit rd_en,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] wd);
    if (!m) begin
      bus.m0_valid = v; bus.m0_rs_en = rs_en; bus.m0_rd_en = rd_en;
      bus.m0_rs1 = rs1; bus.m0_rs2 = rs2; bus.m0_rd = rd; bus.m0_wdata = wd;
    end else begin
      bus.m1_valid = v; bus.m1_rs_en = rs_en; bus.m1_rd_en = rd_en;
      bus.m1_rs1 = rs1; bus.m1_rs2 = rs2; bus.m1_rd = rd; bus.m1_wdata = wd;
    end
  endtask

  task automatic issue(input bit m, input bit rs_en, input bit rd_en, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] wd);
    bit got;
    got = 1'b0;
    set_req(m, 1'b1, rs_en, rd_en, rs1, rs2, rd, wd);
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = m ? bus.m1_ready : bus.m0_ready;
    end
    if (!got) timeout("issue_ready");
    @(posedge clk); #1;
    set_req(m, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
  endtask

  task automatic wait_resp();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = bus.resp_valid && bus.resp_ready;
    end
    if (!got) timeout("wait_resp");
    @(posedge clk); #1;
  endtask

  task automatic tie(input int n);
    int hs;
    hs = 0;
    set_req(1'b0, 1'b1, 1'b1, 1'b0, 5'd1, 5'd2, 5'd0, 32'd0);
    set_req(1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 5'd4, 5'd0, 32'd0);
    for (int i = 0; i < 200 && hs < n; i++) begin
      @(negedge clk);
      if (bus.resp_valid && bus.resp_ready) hs++;
    end
    if (hs < n) timeout("tie_handshakes");
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    set_req(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
  endtask

  task automatic clear_logs();
    grants.delete(); r_id.delete(); r_rs1.delete(); r_rs2.delete();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n, rc, gsz, rsz;
    rst_n = 1'b0;
    bus.resp_ready = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    set_req(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Tie arbitration right after reset: m0 first, then alternate
    tie(4);
    chk32("tie_count", grants.size(), 4);
    if (grants.size() == 4) begin
      chk32("tie_grants", {28'd0, grants[0], grants[1], grants[2], grants[3]}, 32'b0101);
      chk32("tie_resp_ids", {28'd0, r_id[0], r_id[1], r_id[2], r_id[3]}, 32'b0101);
      chk32("tie_m0_rs1", r_rs1[0], 32'h0101_0101);
      chk32("tie_m0_rs2", r_rs2[0], 32'h0202_0202);
      chk32("tie_m1_rs1", r_rs1[1], 32'h0303_0303);
      chk32("tie_m1_rs2", r_rs2[1], 32'h0404_0404);
    end

    // Write then read, including a no-read request returning zeros
    clear_logs();
    issue(1'b0, 1'b0, 1'b1, 5'd7, 5'd8, 5'd5, 32'hDEAD_BEEF); wait_resp();
    issue(1'b0, 1'b1, 1'b0, 5'd5, 5'd0, 5'd0, 32'd0);          wait_resp();
    chk32("wr_resp_rs1_zero", r_rs1[0], 32'd0);
    chk32("wr_resp_rs2_zero", r_rs2[0], 32'd0);
    chk32("rd_rs1", r_rs1[1], 32'hDEAD_BEEF);
    chk32("rd_rs2_x0", r_rs2[1], 32'd0);
    chk1("rd_id", r_id[1], 1'b0);

    // x0 protection
    clear_logs();
    n = wr_low_cnt;
    issue(1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 32'h1234_5678); wait_resp();
    chk32("x0_write_enable_cycles", wr_low_cnt - n, 32'd0);
    chk32("x0_file_untouched", fmem[0], 32'hBAD0_BAD0);
    issue(1'b1, 1'b1, 1'b0, 5'd0, 5'd5, 5'd0, 32'd0); wait_resp();
    chk32("x0_read", r_rs1[1], 32'd0);
    chk32("x0_read_rs2", r_rs2[1], 32'hDEAD_BEEF);
    chk1("x0_id", r_id[1], 1'b1);

    // Collision: read returns pre-write value
    clear_logs();
    issue(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd3, 32'd7); wait_resp();
    issue(1'b0, 1'b1, 1'b1, 5'd3, 5'd0, 5'd3, 32'd9); wait_resp();
    issue(1'b0, 1'b1, 1'b0, 5'd3, 5'd3, 5'd0, 32'd0); wait_resp();
    chk32("collide_old", r_rs1[1], 32'd7);
    chk32("collide_new", r_rs1[2], 32'd9);

    // Backpressure with a competing request waiting
    clear_logs();
    bus.resp_ready = 1'b0;
    issue(1'b1, 1'b1, 1'b0, 5'd3, 5'd5, 5'd0, 32'd0);
    n = 0;
    for (int i = 0; i < 20 && !bus.resp_valid; i++) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.resp_valid) timeout("bp_resp_valid");
    rc = req_cnt;
    gsz = grants.size();
    set_req(1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 5'd3, 5'd0, 32'd0);
    repeat (10) begin @(posedge clk); #1; end
    chk32("bp_no_strobe", req_cnt - rc, 32'd0);
    chk32("bp_no_grant", grants.size() - gsz, 32'd0);
    chk1("bp_resp_held", bus.resp_valid, 1'b1);
    bus.resp_ready = 1'b1;
    wait_resp();
    issue(1'b0, 1'b1, 1'b0, 5'd5, 5'd3, 5'd0, 32'd0); wait_resp();
    chk32("bp_rs1", r_rs1[0], 32'd9);
    chk32("bp_rs2", r_rs2[0], 32'hDEAD_BEEF);
    chk32("bp_next_rs1", r_rs1[1], 32'hDEAD_BEEF);
    chk1("bp_next_id", r_id[1], 1'b0);

    // Reset during STROBE drops the transaction; m0 wins the next tie
    rsz = r_id.size();
    issue(1'b1, 1'b1, 1'b0, 5'd5, 5'd5, 5'd0, 32'd0);
    @(posedge clk); #1;
    chk1("mid_strobe_seen", bus.rf_req, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk32("mid_resp_dropped", r_id.size() - rsz, 32'd0);
    clear_logs();
    tie(2);
    chk32("post_rst_count", grants.size(), 2);
    if (grants.size() == 2) begin
      chk1("post_rst_first", grants[0], 1'b0);
      chk1("post_rst_second", grants[1], 1'b1);
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
